// File: rtl/i2s_mic_array_model_if.sv
// Bundle of the mic array emulator's control inputs and I2S-side outputs.
// master: the emulator (drives the mic lines). slave: the capture side / stimulus.
interface i2s_mic_array_model_if #(
  parameter int unsigned N_CH  = 4,
  parameter int unsigned W     = 16,
  parameter int unsigned DLY_W = 4
);
  logic                    en;
  logic [1:0]              mode;
  logic [N_CH*DLY_W-1:0]   dly;
  logic                    mic_clk;
  logic                    mic_ws;
  logic [N_CH-1:0]         mic_da;
  logic                    frame_strobe;
  logic [W-1:0]            src_sample;

  modport master (
    input  en, mode, dly,
    output mic_clk, mic_ws, mic_da, frame_strobe, src_sample
  );

  modport slave (
    output en, mode, dly,
    input  mic_clk, mic_ws, mic_da, frame_strobe, src_sample
  );
endinterface

// File: rtl/i2s_mic_array_model.sv
// N-channel I2S microphone array emulator. Every channel replays one common source
// stream, each delayed by a programmable whole number of frames.
module i2s_mic_array_model #(
  parameter int unsigned N_CH    = 4,
  parameter int unsigned W       = 16,
  parameter int unsigned CLK_DIV = 8,
  parameter int unsigned MAX_DLY = 12,
  parameter int unsigned DLY_W   = 4,
  parameter logic [15:0] SEED    = 16'hACE1
) (
  input logic                   clk,
  input logic                   rst,
  i2s_mic_array_model_if.master bus
);

  localparam int unsigned     Depth  = MAX_DLY + 1;
  localparam int unsigned     PtrW   = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned     DivW   = $clog2(CLK_DIV);
  localparam logic [DivW-1:0] DivMax = DivW'(CLK_DIV - 1);
  localparam logic [15:0]     AltPat = 16'hAAAA;

  logic [DivW-1:0] div_cnt_q;
  logic            mic_clk_q;
  logic [5:0]      bit_cnt_q;
  logic            frame_strobe_q;
  logic [W-1:0]    src_q;
  logic [15:0]     lfsr_q;
  logic [W-1:0]    ramp_q;
  logic [W-1:0]    hist_q [Depth];
  logic [PtrW-1:0] wr_ptr_q;
  logic [W-1:0]    sh_q [N_CH];
  logic [N_CH-1:0] mic_da_q;

  logic            div_wrap;
  logic            fall;
  logic            frame;
  logic [15:0]     lfsr_d;
  logic [W-1:0]    sample;
  logic [PtrW-1:0] wr_ptr_d;
  logic [W-1:0]    load_val [N_CH];

  // Clock-divider events and the sample the selected generator would emit now.
  always_comb begin
    div_wrap = (div_cnt_q == DivMax);
    fall     = div_wrap & mic_clk_q;
    frame    = fall & (bit_cnt_q == 6'd63);
    lfsr_d   = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
    case (bus.mode)
      2'd0:    sample = lfsr_q[W-1:0];
      2'd1:    sample = ramp_q;
      2'd2:    sample = AltPat[W-1:0];
      default: sample = '0;
    endcase
    wr_ptr_d = (wr_ptr_q == PtrW'(Depth - 1)) ? '0 : wr_ptr_q + 1'b1;
  end

  // Per-channel word for the next frame: delay 0 bypasses the history write in flight.
  always_comb begin
    int unsigned dly_k;
    int unsigned idx;
    dly_k = 0;
    idx   = 0;
    for (int k = 0; k < N_CH; k++) begin
      dly_k = 32'(bus.dly[k*DLY_W +: DLY_W]);
      if (dly_k > MAX_DLY) dly_k = MAX_DLY;
      idx = 32'(wr_ptr_q) + Depth - dly_k;
      if (idx >= Depth) idx = idx - Depth;
      if (!bus.en) begin
        load_val[k] = '0;
      end else if (dly_k == 0) begin
        load_val[k] = sample;
      end else begin
        load_val[k] = hist_q[PtrW'(idx)];
      end
    end
  end

  // Divider, bit counter, generators, history and per-channel serialisers.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q      <= '0;
      mic_clk_q      <= 1'b0;
      bit_cnt_q      <= '0;
      frame_strobe_q <= 1'b0;
      src_q          <= '0;
      lfsr_q         <= SEED;
      ramp_q         <= '0;
      wr_ptr_q       <= '0;
      mic_da_q       <= '0;
      for (int i = 0; i < Depth; i++) hist_q[i] <= '0;
      for (int k = 0; k < N_CH; k++) sh_q[k] <= '0;
    end else begin
      div_cnt_q      <= div_wrap ? '0 : div_cnt_q + 1'b1;
      frame_strobe_q <= frame;
      if (div_wrap) mic_clk_q <= ~mic_clk_q;
      if (fall) bit_cnt_q <= bit_cnt_q + 1'b1;
      if (frame) begin
        if (bus.en) begin
          hist_q[wr_ptr_q] <= sample;
          wr_ptr_q         <= wr_ptr_d;
          src_q            <= sample;
          if (bus.mode == 2'd0) lfsr_q <= lfsr_d;
          if (bus.mode == 2'd1) ramp_q <= ramp_q + 1'b1;
        end
        // Bit 0 of every frame is the I2S one-bit-delay slot.
        mic_da_q <= '0;
        for (int k = 0; k < N_CH; k++) sh_q[k] <= load_val[k];
      end else if (fall) begin
        for (int k = 0; k < N_CH; k++) begin
          if (bit_cnt_q < 6'(W)) begin
            mic_da_q[k] <= sh_q[k][W-1];
            sh_q[k]     <= sh_q[k] << 1;
          end else begin
            mic_da_q[k] <= 1'b0;
          end
        end
      end
    end
  end

  assign bus.mic_clk      = mic_clk_q;
  assign bus.mic_ws       = bit_cnt_q[5];
  assign bus.mic_da       = mic_da_q;
  assign bus.frame_strobe = frame_strobe_q;
  assign bus.src_sample   = src_q;

endmodule

// File: tb/tb_i2s_mic_array_model.sv
// Bench for i2s_mic_array_model: frame-level reference model plus an I2S receiver.
module tb_i2s_mic_array_model;
  localparam int CD   = 8;
  localparam int NCH  = 4;
  localparam int W    = 16;
  localparam int MAXD = 12;
  localparam int FR   = 128 * CD;

  logic clk;
  logic rst;

  i2s_mic_array_model_if #(.N_CH(NCH), .W(W), .DLY_W(4)) bus ();

  i2s_mic_array_model #(
    .N_CH(NCH), .W(W), .CLK_DIV(CD), .MAX_DLY(MAXD), .DLY_W(4), .SEED(16'hACE1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state: time since reset, generator state, emitted samples.
  int          m_t = 0;
  bit          m_rst = 1'b0;
  bit          m_started = 1'b0;
  logic [15:0] m_lfsr;
  logic [15:0] m_ramp;
  logic [15:0] m_src;
  logic [15:0] m_word [NCH];
  logic [15:0] emitted [$];

  // Receiver state, built from the DUT's pins.
  logic [15:0] rx_mem [NCH][64];
  logic [15:0] rx_word [NCH];
  int          rx_n;
  int          rx_idx;
  bit          rx_prev;
  logic [15:0] src_at [64];
  int          frame_no;
  int          first_clk_t, first_ws_t, first_strb_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 30) $display("FAIL %s: got %h, want %h (t=%0d)", name, act, exp, m_t);
    end
  endtask

  task automatic chk_rx(input string name, input int ch, input int j, input logic [15:0] exp);
    if (j < rx_n && j < 64) chk(name, {16'h0, rx_mem[ch][j]}, {16'h0, exp});
    else begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: word %0d not received (got %0d words), want %h", name, j, rx_n, exp);
    end
  endtask

  task automatic chk_src(input string name, input int j, input logic [15:0] exp);
    if (j <= frame_no && j < 64) chk(name, {16'h0, src_at[j]}, {16'h0, exp});
    else begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: strobe %0d not seen (got %0d), want %h", name, j, frame_no, exp);
    end
  endtask

  // Frame-level model: on every frame boundary emit/push a sample and pick each
  // channel's word as the sample emitted d boundaries ago.
  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        m_rst     = 1'b1;
        m_started = 1'b1;
        m_t       = 0;
        m_lfsr    = 16'hACE1;
        m_ramp    = 16'h0;
        m_src     = 16'h0;
        emitted.delete();
        for (int k = 0; k < NCH; k++) m_word[k] = 16'h0;
      end else begin
        m_rst = 1'b0;
        m_t++;
        if (m_t % FR == 0) begin
          if (bus.en) begin
            logic [15:0] s;
            case (bus.mode)
              2'd0: s = m_lfsr;
              2'd1: s = m_ramp;
              2'd2: s = 16'hAAAA;
              default: s = 16'h0;
            endcase
            emitted.push_back(s);
            if (bus.mode == 2'd0)
              m_lfsr = {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
            if (bus.mode == 2'd1) m_ramp = m_ramp + 16'd1;
            m_src = s;
            for (int k = 0; k < NCH; k++) begin
              int d;
              int n;
              d = int'(bus.dly[k*4 +: 4]);
              if (d > MAXD) d = MAXD;
              n = emitted.size();
              m_word[k] = (n > d) ? emitted[n-1-d] : 16'h0;
            end
          end else begin
            for (int k = 0; k < NCH; k++) m_word[k] = 16'h0;
          end
        end
      end
    end
  end

  // Compare process: pin-level expectations derived from elapsed time, plus receiver.
  initial begin
    forever begin
      @(negedge clk);
      if (m_started) begin
        int          bitn;
        logic [3:0]  exp_da;
        logic        exp_clk, exp_ws, exp_strb;
        exp_clk  = ((m_t / CD) % 2) == 1;
        bitn     = (m_t / (2 * CD)) % 64;
        exp_ws   = bitn >= 32;
        exp_strb = !m_rst && m_t > 0 && (m_t % FR == 0);
        for (int k = 0; k < NCH; k++)
          exp_da[k] = (bitn >= 1 && bitn <= W) ? m_word[k][W-bitn] : 1'b0;
        chk("mic_clk", {31'h0, bus.mic_clk}, {31'h0, exp_clk});
        chk("mic_ws", {31'h0, bus.mic_ws}, {31'h0, exp_ws});
        chk("frame_strobe", {31'h0, bus.frame_strobe}, {31'h0, exp_strb});
        chk("src_sample", {16'h0, bus.src_sample}, {16'h0, m_src});
        chk("mic_da", {28'h0, bus.mic_da}, {28'h0, exp_da});

        if (m_rst) begin
          rx_n = 0; rx_idx = 0; rx_prev = 1'b0; frame_no = 0;
          first_clk_t = -1; first_ws_t = -1; first_strb_t = -1;
        end else begin
          if (bus.mic_clk && first_clk_t < 0) first_clk_t = m_t;
          if (bus.mic_ws && first_ws_t < 0) first_ws_t = m_t;
          if (bus.frame_strobe && first_strb_t < 0) first_strb_t = m_t;
          if (bus.frame_strobe) begin
            rx_idx = 0;
            frame_no++;
            if (frame_no < 64) src_at[frame_no] = bus.src_sample;
          end
          if (bus.mic_clk && !rx_prev) begin
            if (rx_idx >= 1 && rx_idx <= W) begin
              for (int k = 0; k < NCH; k++) rx_word[k] = {rx_word[k][14:0], bus.mic_da[k]};
              if (rx_idx == W) begin
                if (rx_n < 64) for (int k = 0; k < NCH; k++) rx_mem[k][rx_n] = rx_word[k];
                rx_n++;
              end
            end
            rx_idx++;
          end
          rx_prev = bus.mic_clk;
        end
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  task automatic wait_t(input int tt);
    int g;
    g = 0;
    while (m_t < tt && g < 200000) begin
      @(posedge clk);
      #2;
      g++;
    end
    if (g >= 200000) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_t: timeout at t=%0d, want t=%0d", m_t, tt);
    end
  endtask

  initial begin
    rst      = 1'b1;
    bus.en   = 1'b1;
    bus.mode = 2'd1;
    bus.dly  = 16'h0000;

    // Reset timing and ramp with all delays 0.
    do_reset();
    wait_t(5 * FR + 400);
    chk("first_mic_clk_rise", 32'(first_clk_t), 32'd8);
    chk("first_ws_rise", 32'(first_ws_t), 32'd512);
    chk("first_strobe", 32'(first_strb_t), 32'd1024);
    for (int k = 0; k < NCH; k++) chk_rx("ramp_d0_frame3", k, 3, 16'd2);
    chk_src("ramp_src_frame4", 4, 16'd3);

    // Ramp with per-channel lags 3,2,1,0.
    bus.dly = 16'h3210;
    do_reset();
    wait_t(6 * FR + 400);
    chk_rx("lag3_frame4", 3, 4, 16'd0);
    chk_rx("lag3_frame6", 3, 6, 16'd2);
    chk_rx("lag2_frame6", 2, 6, 16'd3);
    chk_rx("lag1_frame6", 1, 6, 16'd4);
    chk_rx("lag0_frame6", 0, 6, 16'd5);

    // LFSR sequence from the seed.
    bus.mode = 2'd0;
    bus.dly  = 16'h5000;
    do_reset();
    wait_t(4 * FR + 400);
    chk_src("lfsr_src1", 1, 16'hACE1);
    chk_src("lfsr_src2", 2, 16'h5670);
    chk_src("lfsr_src3", 3, 16'hAB38);
    chk_rx("lfsr_da1", 0, 1, 16'hACE1);
    chk_rx("lfsr_da2", 0, 2, 16'h5670);
    chk_rx("lfsr_da3", 0, 3, 16'hAB38);

    // Reset asserted at bit_cnt 20 of a running LFSR frame.
    wait_t(5 * FR + 324);
    rst = 1'b1;
    @(posedge clk);
    #2;
    rst = 1'b0;
    chk("midrst_src", {16'h0, bus.src_sample}, 32'h0);
    chk("midrst_clk", {31'h0, bus.mic_clk}, 32'h0);
    chk("midrst_da", {28'h0, bus.mic_da}, 32'h0);
    wait_t(FR + 300);
    chk_src("midrst_restart_src", 1, 16'hACE1);
    chk_rx("midrst_restart_da", 0, 1, 16'hACE1);

    // Delay clamp (14 -> 12) and enable drop/re-raise mid-frame.
    bus.mode = 2'd1;
    bus.dly  = 16'hC5E0;
    do_reset();
    wait_t(16 * FR + 170);
    bus.en = 1'b0;
    wait_t(18 * FR + 500);
    bus.en = 1'b1;
    wait_t(19 * FR + 400);
    chk_rx("en_frame16_intact", 0, 16, 16'd15);
    chk_rx("clamp14_frame16", 1, 16, 16'd3);
    chk_rx("dly12_frame16", 3, 16, 16'd3);
    chk_rx("en_low_frame17", 0, 17, 16'd0);
    chk_rx("en_low_frame18", 0, 18, 16'd0);
    chk_src("en_low_src17", 17, 16'd15);
    chk_src("en_low_src18", 18, 16'd15);
    chk_src("en_resume_src19", 19, 16'd16);
    chk_rx("en_resume_frame19", 0, 19, 16'd16);
    chk_rx("clamp14_frame19", 1, 19, 16'd4);

    // Random mode/delay/enable changes at arbitrary cycles.
    bus.mode = 2'($urandom_range(0, 3));
    bus.dly  = 16'($urandom);
    do_reset();
    repeat (15 * FR) begin
      int r;
      @(posedge clk);
      #2;
      r = $urandom_range(0, 399);
      if (r == 0) bus.mode = 2'($urandom_range(0, 3));
      if (r == 1) bus.dly = 16'($urandom);
      if (r == 2) bus.en = ($urandom_range(0, 3) != 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/i2s_mic_array_model.md
# i2s_mic_array_model

Synthesizable N-channel I2S microphone array emulator for on-chip loopback of the mic capture / cross-correlation path. It generates the mic bit clock and word select, and drives one serial data line per channel. Each channel replays a common source sample stream delayed by a programmable whole number of frames, giving known inter-channel lags against which xcorr results are checked. It replaces ad-hoc two-mic bench stimulus, and can sit in the top in place of the PAD_MICx_DA inputs.

## Interface
Parameters:
- N_CH, 4: number of emulated mics.
- W, 16: sample width, 1..16.
- CLK_DIV, 8: clk cycles per mic_clk half-period, ≥2.
- MAX_DLY, 12: maximum per-channel delay in frames.
- DLY_W, 4: width of each delay field.
- SEED, 16'hACE1: LFSR reset value, must be nonzero.

Ports:
- clk  in  1  system clock; everything is on its rising edge.
- rst  in  1  reset. It is synchronous and active-high, and forces the reset state described below.
- en  in  1  source enable. It is sampled only at frame boundaries.
- mode  in  2  source select, sampled at frame boundaries: 0 = LFSR, 1 = ramp, 2 = alternating pattern, 3 = zero.
- dly  in  N_CH*DLY_W  per-channel delay in frames. Channel k uses bits [k*DLY_W +: DLY_W]. Sampled at frame boundaries.
- mic_clk  out  1  emulated I2S bit clock.
- mic_ws  out  1  word select: 0 = left slot (data), 1 = right slot.
- mic_da  out  N_CH  serial data, one bit per channel.
- frame_strobe  out  1  one-clk pulse at each frame boundary.
- src_sample  out  W  newest source sample, i.e. the value a delay-0 channel is sending. Held for one frame.

## Operation
- **Divider**
  - div_cnt counts 0..CLK_DIV-1.
  - mic_clk toggles when div_cnt = CLK_DIV-1, so the mic_clk period is 2*CLK_DIV clk cycles.
  - mic_clk comes out of reset low.
- **Bit counter**
  - bit_cnt is 6 bits and advances on each mic_clk falling edge (the clk cycle in which mic_clk goes 1→0). It wraps 63→0.
  - mic_ws = bit_cnt[5], so a frame is 64 bit clocks: 32 left, then 32 right.
- **Frame boundary** (the falling edge on which bit_cnt wraps to 0):
  - Latch en, mode and dly.
  - If en is high, emit a new source sample. Push it into the circular history (depth MAX_DLY+1) at wr_ptr, advance wr_ptr, and advance the selected generator.
  - Load each channel's shift register with history[wr_ptr - d_k], where d_k = min(dly_k, MAX_DLY). d_k = 0 gives the sample just pushed.
  - If en is low, the history is not written and all shift registers load 0.
  - Pulse frame_strobe.
- **Generators.** Each advances only while it is the selected mode and en is high; its state is retained otherwise.
  - LFSR: emitted sample = lfsr[W-1:0]. Then fb = l[0]^l[2]^l[3]^l[5]; l ← {fb, l[15:1]}.
  - Ramp: emits 0, 1, 2, … and wraps mod 2^W.
  - Mode 2: emits the low W bits of 16'hAAAA.
  - Mode 3: emits 0.
- **Serialisation**
  - I2S has a one-bit delay: mic_da = 0 at bit_cnt 0.
  - At bit_cnt = 1..W, mic_da carries the sample MSB first.
  - At bit_cnt = W+1..63, mic_da = 0. The whole right slot is 0.
  - mic_da changes only on mic_clk falling edges. It is stable on rising edges, where the capture block samples.
- **Reset state**
  - Outputs: mic_clk = 0, mic_ws = 0, mic_da = 0, frame_strobe = 0, src_sample = 0.
  - Internal: div_cnt = 0, bit_cnt = 0, lfsr = SEED, ramp = 0, history all 0, wr_ptr = 0, shift registers 0.
  - Frame 0 after reset transmits zeros.

## Timing
- mic_clk rises CLK_DIV cycles after rst deasserts. Its first falling edge is at 2*CLK_DIV cycles.
- mic_ws first rises at 64*CLK_DIV cycles.
- The first frame_strobe is at 128*CLK_DIV cycles. Subsequent strobes come every 128*CLK_DIV cycles.
- src_sample and all shift registers update in the same cycle as frame_strobe.
- The MSB appears on mic_da one mic_clk period (2*CLK_DIV cycles) after frame_strobe.
- A channel with delay d outputs the sample emitted d frame boundaries earlier. Before d enabled boundaries have occurred, its history slot is unwritten and it outputs 0.
- Changes to en, mode or dly mid-frame never disturb the frame in progress.
- rst asserted at any point, including mid-frame, returns every register to the reset state on the next clk edge. Timing restarts from that edge.

## Test plan
- **Reset:** apply rst, release it, CLK_DIV = 8 → all outputs 0; mic_clk rises at cycle 8; mic_ws rises at cycle 512; frame_strobe first at cycle 1024.
- **Ramp, dly all 0, en = 1, W = 16:** a receiver sampling mic_da on mic_clk rising edges in the left slot, bits 1..16, reads 0, 1, 2, … on every channel; all other bits read 0.
- **Ramp, dly = {3,2,1,0} (ch3..ch0):** ch k reads k zero words, then 0, 1, 2, …; ch k always lags ch0 by exactly k frames.
- **LFSR, SEED = ACE1:** src_sample reads 16'hACE1, 16'h5670, 16'hAB38 in successive frames; mic_da matches bit for bit.
- **Enable and delay clamp:** drop en mid-frame → the current frame completes unchanged, following frames carry all-zero data, and src_sample does not advance; re-raise en → the next generator value resumes. With dly_k = 14 and MAX_DLY = 12, the channel lags by 12 frames.
- **Reset mid-frame:** assert rst at bit_cnt = 20 in LFSR mode → the next cycle shows the reset state, and the sequence restarts at 16'hACE1.
